// File: rtl/relu_maxpool_stage.sv
// ReLU (or ReLU6 when RELU_CLIP6_EN is defined) followed by an optional 2x2/stride-2 max pool.
// Latency: one cycle from the accepted input to out_valid. With pooling, output appears only on odd-row/odd-col inputs.
// Valid-only stream with no backpressure: an idle in_valid cycle freezes all counters and pool state.
module relu_maxpool_stage #(
    parameter int IN_CHANNELS = 4,
    parameter int IMAGE_WIDTH = 128,
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 8,
    parameter int MAX_POOL    = 0
) (
    input  logic                                                     clk,
    input  logic                                                     rst,
    input  logic                                                     in_valid,
    input  logic                                                     in_sof,
    input  logic signed [DATA_WIDTH-1:0]                             in_data,
    input  logic                                                     relu_en,
    output logic                                                     out_valid,
    output logic signed [DATA_WIDTH-1:0]                             out_data,
    output logic [((IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1)-1:0] out_channel,
    output logic                                                     out_eol
);

    localparam int CW       = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
    localparam int XW       = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int HALF_W   = (IMAGE_WIDTH / 2 > 0) ? IMAGE_WIDTH / 2 : 1;
    localparam int LB_DEPTH = HALF_W * IN_CHANNELS;
    localparam int LW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

`ifdef RELU_CLIP6_EN
    localparam bit CLIP6 = 1'b1;
`else
    localparam bit CLIP6 = 1'b0;
`endif
    localparam logic signed [DATA_WIDTH-1:0] SIX     = DATA_WIDTH'(6 << FRAC_BITS);
    localparam logic signed [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    // Upper clamp; the most positive value makes the clamp a no-op for plain ReLU.
    localparam logic signed [DATA_WIDTH-1:0] RELU_MAX = CLIP6 ? SIX : MAX_POS;

    logic [CW-1:0]                  ch;
    logic [XW-1:0]                  col;
    logic                           row_odd;
    logic signed [DATA_WIDTH-1:0]   hold    [IN_CHANNELS];
    logic signed [DATA_WIDTH-1:0]   linebuf [LB_DEPTH];

    logic signed [DATA_WIDTH-1:0]   relu_r;
    logic [CW-1:0]                  ch_e;
    logic [XW-1:0]                  col_e;
    logic                           row_odd_e;
    logic                           last_ch;
    logic                           last_col;
    logic [LW-1:0]                  lb_idx;

    function automatic logic signed [DATA_WIDTH-1:0] smax(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // ReLU with optional upper clamp; relu_en=0 passes the sample untouched.
    always_comb begin
        relu_r = in_data;
        if (relu_en) begin
            if (in_data < 0)
                relu_r = '0;
            else if (in_data > RELU_MAX)
                relu_r = RELU_MAX;
        end
    end

    // Position of the current sample; in_sof restarts the frame before this sample is used.
    always_comb begin
        ch_e      = in_sof ? '0 : ch;
        col_e     = in_sof ? '0 : col;
        row_odd_e = in_sof ? 1'b0 : row_odd;
        last_ch   = (ch_e == CW'(IN_CHANNELS - 1));
        last_col  = (col_e == XW'(IMAGE_WIDTH - 1));
        lb_idx    = LW'((int'(col_e) >> 1) * IN_CHANNELS + int'(ch_e));
    end

    // Stream counters, pool state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch          <= '0;
            col         <= '0;
            row_odd     <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
            out_eol     <= 1'b0;
            for (int i = 0; i < IN_CHANNELS; i++)
                hold[i] <= '0;
            for (int i = 0; i < LB_DEPTH; i++)
                linebuf[i] <= '0;
        end else begin
            if (in_valid) begin
                ch      <= last_ch ? '0 : ch_e + 1'b1;
                col     <= last_ch ? (last_col ? '0 : col_e + 1'b1) : col_e;
                row_odd <= (last_ch && last_col) ? ~row_odd_e : row_odd_e;
            end

            if (MAX_POOL == 0) begin
                out_valid   <= in_valid;
                out_data    <= relu_r;
                out_channel <= ch_e;
                out_eol     <= in_valid && last_ch && last_col;
            end else begin
                out_valid <= 1'b0;
                out_eol   <= 1'b0;
                if (in_valid) begin
                    case ({row_odd_e, col_e[0]})
                        2'b00: hold[ch_e]      <= relu_r;
                        2'b01: linebuf[lb_idx] <= smax(hold[ch_e], relu_r);
                        2'b10: hold[ch_e]      <= smax(linebuf[lb_idx], relu_r);
                        default: begin
                            out_valid   <= 1'b1;
                            out_data    <= smax(hold[ch_e], relu_r);
                            out_channel <= ch_e;
                            out_eol     <= last_ch && last_col;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_relu_maxpool_stage.sv
// Bench for relu_maxpool_stage: three instances (ReLU only; pool C=1 W=4; pool C=2 W=2).
// Expected samples are queued with their due cycle when stimulus is driven, popped when out_valid rises.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_relu_maxpool_stage;

    typedef struct {
        int d;
        int ch;
        int eol;
        int due;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic               in_sof = 1'b0;
    logic signed [15:0] in_data = '0;
    logic               relu_en = 1'b0;

    logic               ov0, ov1, ov2;
    logic signed [15:0] od0, od1, od2;
    logic [0:0]         oc0, oc1, oc2;
    logic               oe0, oe1, oe2;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q0[$], q1[$], q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    relu_maxpool_stage #(.IN_CHANNELS(1), .IMAGE_WIDTH(4), .DATA_WIDTH(16), .FRAC_BITS(8), .MAX_POOL(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_sof(in_sof), .in_data(in_data), .relu_en(relu_en),
        .out_valid(ov0), .out_data(od0), .out_channel(oc0), .out_eol(oe0));
    relu_maxpool_stage #(.IN_CHANNELS(1), .IMAGE_WIDTH(4), .DATA_WIDTH(16), .FRAC_BITS(8), .MAX_POOL(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_sof(in_sof), .in_data(in_data), .relu_en(relu_en),
        .out_valid(ov1), .out_data(od1), .out_channel(oc1), .out_eol(oe1));
    relu_maxpool_stage #(.IN_CHANNELS(2), .IMAGE_WIDTH(2), .DATA_WIDTH(16), .FRAC_BITS(8), .MAX_POOL(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_sof(in_sof), .in_data(in_data), .relu_en(relu_en),
        .out_valid(ov2), .out_data(od2), .out_channel(oc2), .out_eol(oe2));

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference activation: ReLU, plus the 6.0 clamp (FRAC_BITS=8) in the clip build.
    function automatic int relu_m(input int d, input bit re);
        int r;
        r = d;
        if (re && d < 0)
            r = 0;
`ifdef RELU_CLIP6_EN
        if (re && d > (6 << 8))
            r = 6 << 8;
`endif
        return r;
    endfunction

    task automatic send(input int inst, input bit sof, input int d, input bit re);
        @(posedge clk);
        #1;
        v0      = (inst == 0);
        v1      = (inst == 1);
        v2      = (inst == 2);
        in_sof  = sof;
        in_data = 16'(d);
        relu_en = re;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        v0     = 1'b0;
        v1     = 1'b0;
        v2     = 1'b0;
        in_sof = 1'b0;
    endtask

    // Called right after send(): the result is due on the next clock.
    task automatic push(input int inst, input int d, input int ch, input int eol);
        exp_t e;
        e.d   = d;
        e.ch  = ch;
        e.eol = eol;
        e.due = cyc + 1;
        case (inst)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic mon(input int inst, input logic v, input int d, input int c, input int eol);
        exp_t e;
        int   sz;
        if (v) begin
            sz = (inst == 0) ? q0.size() : (inst == 1) ? q1.size() : q2.size();
            if (sz == 0) begin
                chk($sformatf("unexpected_out%0d", inst), 1, 0);
            end else begin
                case (inst)
                    0:       e = q0.pop_front();
                    1:       e = q1.pop_front();
                    default: e = q2.pop_front();
                endcase
                chk($sformatf("data%0d", inst), d, e.d);
                chk($sformatf("chan%0d", inst), c, e.ch);
                chk($sformatf("eol%0d", inst), eol, e.eol);
                chk($sformatf("latency%0d", inst), cyc, e.due);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, ov0, int'(od0), int'(oc0), int'(oe0));
            mon(1, ov1, int'(od1), int'(oc1), int'(oe1));
            mon(2, ov2, int'(od2), int'(oc2), int'(oe2));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a[8];
        int s[8];
        bit re[8];
        int mx[2];

        // Reset held with in_valid asserted on every instance.
        @(posedge clk); #1;
        v0 = 1'b1; v1 = 1'b1; v2 = 1'b1; in_data = 16'sd5; relu_en = 1'b1; in_sof = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid0", int'(ov0), 0);
        chk("rst_data0", int'(od0), 0);
        chk("rst_chan0", int'(oc0), 0);
        chk("rst_eol0", int'(oe0), 0);
        chk("rst_valid1", int'(ov1), 0);
        chk("rst_valid2", int'(ov2), 0);
        chk("rst_data2", int'(od2), 0);
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; in_sof = 1'b0; rst = 1'b0;
        idle();

        // ReLU only: -5 -> 0, 7 -> 7, pass-through -3, row end on column 3.
        send(0, 1, -5, 1); push(0, 0, 0, 0);
        send(0, 0, 7, 1);  push(0, 7, 0, 0);
        send(0, 0, -3, 0); push(0, -3, 0, 0);
        send(0, 0, 2, 1);  push(0, 2, 0, 1);
        send(0, 0, -9, 1); push(0, 0, 0, 0);
        idle(); idle();
        // Clamp behaviour (8.0 in Q8.8), and relu_en=0 bypass.
        send(0, 1, 'h0800, 1); push(0, relu_m('h0800, 1), 0, 0);
        send(0, 0, 'h0800, 0); push(0, 'h0800, 0, 0);
        send(0, 0, 'h7000, 1); push(0, relu_m('h7000, 1), 0, 0);
        send(0, 0, 'h0600, 1); push(0, 'h0600, 0, 1);
        idle(); idle();

        // Pool C=1 W=4: rows [1,-2,3,9] [4,0,-8,2] -> 4, then 9 with eol; back-to-back then with gaps.
        a = '{1, -2, 3, 9, 4, 0, -8, 2};
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 8; i++) begin
                if (pass == 1 && $urandom_range(0, 1) == 1)
                    idle();
                send(1, i == 0, a[i], 1);
                if (i == 5) push(1, 4, 0, 0);
                if (i == 7) push(1, 9, 0, 1);
            end
            idle(); idle();
        end

        // All-negative frame with ReLU off: signed maxima -2 and -1.
        a = '{-4, -2, -7, -1, -3, -5, -6, -8};
        for (int i = 0; i < 8; i++) begin
            send(1, i == 0, a[i], 0);
            if (i == 5) push(1, -2, 0, 0);
            if (i == 7) push(1, -1, 0, 1);
        end
        idle(); idle();

        // Large values left half-processed, then in_sof mid-row: only the new frame may appear.
        for (int i = 0; i < 5; i++)
            send(1, i == 0, 100, 1);
        a = '{1, 2, 3, 4, 5, 6, 7, 8};
        for (int i = 0; i < 8; i++) begin
            send(1, i == 0, a[i], 1);
            if (i == 5) push(1, 6, 0, 0);
            if (i == 7) push(1, 8, 0, 1);
        end
        idle(); idle();

        // Reset mid-frame discards pool state; the following frame starts with in_sof.
        for (int i = 0; i < 6; i++)
            send(1, i == 0, 90, 1);
        @(posedge clk); #1;
        v1 = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(1, i == 0, a[7 - i], 1);
            if (i == 5) push(1, 8, 0, 0);
            if (i == 7) push(1, 6, 0, 1);
        end
        idle(); idle();

        // Pool C=2 W=2: random channel-interleaved frames with random gaps.
        for (int f = 0; f < 4; f++) begin
            mx[0] = -100000;
            mx[1] = -100000;
            for (int i = 0; i < 8; i++) begin
                s[i]  = int'($urandom_range(0, 100)) - 50;
                re[i] = bit'($urandom_range(0, 1));
                if (relu_m(s[i], re[i]) > mx[i % 2])
                    mx[i % 2] = relu_m(s[i], re[i]);
            end
            for (int i = 0; i < 8; i++) begin
                repeat ($urandom_range(0, 2)) idle();
                send(2, i == 0, s[i], re[i]);
                if (i == 6) push(2, mx[0], 0, 0);
                if (i == 7) push(2, mx[1], 1, 1);
            end
        end
        repeat (4) idle();

        chk("drain0", q0.size(), 0);
        chk("drain1", q1.size(), 0);
        chk("drain2", q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
